// File: rtl/dti_pr_rsp_arbiter.sv
// Packet-atomic response arbiter: two-class QoS, round-robin within a class,
// starvation promotion, and a single registered output slot toward the async bridge.

module dti_pr_rsp_arb_lane #(
   parameter int STARVE_LIMIT = 7,
   parameter int CW           = 3
) (
   input  logic clk,
   input  logic rst,
   input  logic valid_i,
   input  logic qos_i,
   input  logic start_i,
   input  logic win_i,
   output logic hi_o
);
   logic [CW-1:0] wait_q, wait_d;

   // Counters move only at packet-start decisions.
   always_comb begin
      wait_d = wait_q;
      if (start_i) begin
         if (win_i)
            wait_d = '0;
         else if (valid_i && wait_q != CW'(STARVE_LIMIT))
            wait_d = wait_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) wait_q <= '0;
      else     wait_q <= wait_d;
   end

   assign hi_o = qos_i | (wait_q == CW'(STARVE_LIMIT));
endmodule

module dti_pr_rsp_arbiter #(
   parameter int N_SRC        = 4,
   parameter int PLD_WIDTH    = 90,
   parameter int ID_WIDTH     = 6,
   parameter int STARVE_LIMIT = 7
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [N_SRC-1:0]              in_valid_i,
   input  logic [N_SRC*PLD_WIDTH-1:0]    in_payload_i,
   input  logic [N_SRC-1:0]              in_last_i,
   input  logic [N_SRC*ID_WIDTH-1:0]     in_srcid_i,
   input  logic [N_SRC*ID_WIDTH-1:0]     in_tgtid_i,
   input  logic [N_SRC-1:0]              in_qos_i,
   output logic [N_SRC-1:0]              in_ready_o,
   output logic                          out_valid_o,
   output logic [PLD_WIDTH-1:0]          out_payload_o,
   output logic                          out_last_o,
   output logic [ID_WIDTH-1:0]           out_srcid_o,
   output logic [ID_WIDTH-1:0]           out_tgtid_o,
   output logic                          out_qos_o,
   input  logic                          out_ready_i,
   output logic                          lock_active_o,
   output logic [$clog2(N_SRC)-1:0]      lock_id_o
);
   localparam int IW = $clog2(N_SRC);
   localparam int CW = $clog2(STARVE_LIMIT + 1);

   typedef enum logic {S_IDLE, S_LOCKED} state_e;
   state_e state_q, state_d;

   logic [IW-1:0]        rr_q, lock_id_q, pick, grant;
   logic                 pick_vld, gvld, slot_free, acc, start, sel_last;
   logic [N_SRC-1:0]     hi, cand;

   logic                 out_valid_q, out_last_q, out_qos_q;
   logic [PLD_WIDTH-1:0] out_payload_q;
   logic [ID_WIDTH-1:0]  out_srcid_q, out_tgtid_q;

   for (genvar i = 0; i < N_SRC; i++) begin : g_lane
      dti_pr_rsp_arb_lane #(.STARVE_LIMIT(STARVE_LIMIT), .CW(CW)) u_lane (
         .clk    (clk),
         .rst    (rst),
         .valid_i(in_valid_i[i]),
         .qos_i  (in_qos_i[i]),
         .start_i(start),
         .win_i  (grant == IW'(i)),
         .hi_o   (hi[i])
      );
   end

   // High class masks out the low class whenever any high-class source is pending.
   assign cand = in_valid_i & ((|(in_valid_i & hi)) ? hi : {N_SRC{1'b1}});

   always_comb begin
      pick     = '0;
      pick_vld = 1'b0;
      for (int k = 0; k < N_SRC; k++) begin
         if (!pick_vld && cand[(int'(rr_q) + k) % N_SRC]) begin
            pick     = IW'((int'(rr_q) + k) % N_SRC);
            pick_vld = 1'b1;
         end
      end
   end

   assign slot_free = !out_valid_q | out_ready_i;
   assign grant     = (state_q == S_LOCKED) ? lock_id_q : pick;
   assign gvld      = (state_q == S_LOCKED) | pick_vld;

   always_comb begin
      in_ready_o = '0;
      for (int i = 0; i < N_SRC; i++)
         in_ready_o[i] = !rst & slot_free & gvld & (grant == IW'(i));
   end

   assign acc      = |(in_valid_i & in_ready_o);
   assign start    = acc & (state_q == S_IDLE);
   assign sel_last = in_last_i[grant];

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (start && !sel_last) state_d = S_LOCKED;
         S_LOCKED: if (acc && sel_last)    state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= S_IDLE;
         rr_q          <= '0;
         lock_id_q     <= '0;
         out_valid_q   <= 1'b0;
         out_payload_q <= '0;
         out_last_q    <= 1'b0;
         out_srcid_q   <= '0;
         out_tgtid_q   <= '0;
         out_qos_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         if (start) begin
            rr_q      <= (grant == IW'(N_SRC - 1)) ? '0 : grant + 1'b1;
            lock_id_q <= grant;
         end
         if (acc) begin
            out_valid_q   <= 1'b1;
            out_payload_q <= in_payload_i[int'(grant)*PLD_WIDTH +: PLD_WIDTH];
            out_last_q    <= sel_last;
            out_srcid_q   <= in_srcid_i[int'(grant)*ID_WIDTH +: ID_WIDTH];
            out_tgtid_q   <= in_tgtid_i[int'(grant)*ID_WIDTH +: ID_WIDTH];
            out_qos_q     <= in_qos_i[grant];
         end else if (out_ready_i) begin
            out_valid_q <= 1'b0;
         end
      end
   end

   assign out_valid_o   = out_valid_q;
   assign out_payload_o = out_payload_q;
   assign out_last_o    = out_last_q;
   assign out_srcid_o   = out_srcid_q;
   assign out_tgtid_o   = out_tgtid_q;
   assign out_qos_o     = out_qos_q;
   assign lock_active_o = (state_q == S_LOCKED);
   assign lock_id_o     = lock_id_q;
endmodule

// File: tb/tb_dti_pr_rsp_arbiter.sv
// Directed bench for dti_pr_rsp_arbiter: 4 sources, hand-computed grant orders.

module tb_dti_pr_rsp_arbiter;
   localparam int N = 4, PW = 90, IDW = 6, SL = 7;

   logic            clk, rst;
   logic [N-1:0]    in_valid, in_last, in_qos, in_ready;
   logic [N*PW-1:0] in_payload;
   logic [N*IDW-1:0] in_srcid, in_tgtid;
   logic            out_valid, out_last, out_qos, out_ready, lock_active;
   logic [PW-1:0]   out_payload;
   logic [IDW-1:0]  out_srcid, out_tgtid;
   logic [1:0]      lock_id;

   dti_pr_rsp_arbiter #(.N_SRC(N), .PLD_WIDTH(PW), .ID_WIDTH(IDW), .STARVE_LIMIT(SL)) dut (
      .clk(clk), .rst(rst),
      .in_valid_i(in_valid), .in_payload_i(in_payload), .in_last_i(in_last),
      .in_srcid_i(in_srcid), .in_tgtid_i(in_tgtid), .in_qos_i(in_qos),
      .in_ready_o(in_ready),
      .out_valid_o(out_valid), .out_payload_o(out_payload), .out_last_o(out_last),
      .out_srcid_o(out_srcid), .out_tgtid_o(out_tgtid), .out_qos_o(out_qos),
      .out_ready_i(out_ready),
      .lock_active_o(lock_active), .lock_id_o(lock_id)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk = 0, n_bad = 0;
   int en[N], qos[N], len[N], beat[N];
   logic [N-1:0] rdy_seen;

   int exp1[8]  = '{0,1,2,3,0,1,2,3};
   int exp2s[5] = '{1,1,1,1,2};
   int exp2l[5] = '{1,1,1,0,0};
   int exp2t[5] = '{0,0,0,1,1};
   int exp3[16] = '{0,0,0,0,0,0,0,3,0,0,0,0,0,0,0,3};
   int exp6[9]  = '{2,3,2,3,2,3,2,3,0};

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   function automatic logic [PW-1:0] pay(input int i, input int b);
      return {42'(i + 1), 48'(b * 7 + 3)};
   endfunction

   task automatic drive();
      for (int i = 0; i < N; i++) begin
         in_valid[i] = (en[i] != 0);
         in_qos[i]   = (qos[i] != 0);
         in_last[i]  = (beat[i] == len[i] - 1);
         in_payload[i*PW +: PW]  = pay(i, beat[i]);
         in_srcid[i*IDW +: IDW]  = IDW'(i);
         in_tgtid[i*IDW +: IDW]  = IDW'(i + 16);
      end
   endtask

   // One clock: capture handshakes just before the edge, then advance the sources.
   task automatic cyc();
      logic [N-1:0] acc;
      #2;
      rdy_seen = in_ready;
      acc = in_valid & in_ready;
      @(posedge clk); #1;
      for (int i = 0; i < N; i++)
         if (acc[i]) beat[i] = (beat[i] + 1 == len[i]) ? 0 : beat[i] + 1;
      drive();
   endtask

   task automatic setup(input int e0, e1, e2, e3, q0, q1, q2, q3);
      en  = '{e0, e1, e2, e3};
      qos = '{q0, q1, q2, q3};
      len = '{1, 1, 1, 1};
   endtask

   task automatic do_reset();
      rst = 1'b1;
      beat = '{0, 0, 0, 0};
      drive();
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; out_ready = 1'b1;
      setup(1,1,1,1, 0,0,0,0);
      beat = '{0, 0, 0, 0};
      drive();
      #1;
      // Reset state, with every source requesting.
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_lock", lock_active, 0);
      chk("rst_lock_id", lock_id, 0);
      chk("rst_srcid", out_srcid, 0);
      chk("rst_payload", out_payload, 0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Round-robin of single-beat packets, one per cycle.
      for (int k = 0; k < 8; k++) begin
         cyc();
         if (k == 0) chk("rr_first_ready", rdy_seen, 4'b0001);
         chk($sformatf("rr_valid%0d", k), out_valid, 1);
         chk($sformatf("rr_src%0d", k), out_srcid, exp1[k]);
         chk($sformatf("rr_lock%0d", k), lock_active, 0);
      end
      chk("rr_payload", out_payload, pay(3, 0));
      chk("rr_tgtid", out_tgtid, 19);

      // Four-beat packet from 1 is not interleaved with 2.
      setup(0,1,1,0, 0,0,0,0);
      len[1] = 4;
      do_reset();
      for (int k = 0; k < 5; k++) begin
         cyc();
         chk($sformatf("pkt_src%0d", k), out_srcid, exp2s[k]);
         chk($sformatf("pkt_lock%0d", k), lock_active, exp2l[k]);
         chk($sformatf("pkt_last%0d", k), out_last, exp2t[k]);
         if (k == 2) chk("pkt_payload", out_payload, pay(1, 2));
      end

      // Starvation promotion of low-class source 3 against high-class source 0.
      setup(1,0,0,1, 1,0,0,0);
      do_reset();
      for (int k = 0; k < 16; k++) begin
         cyc();
         chk($sformatf("starve_src%0d", k), out_srcid, exp3[k]);
         if (k == 7) chk("starve_qos", out_qos, 0);
         if (k == 8) chk("starve_qos_hi", out_qos, 1);
      end

      // Backpressure holds the slot and blocks every source.
      setup(1,1,0,0, 0,0,0,0);
      do_reset();
      cyc(); chk("bp_src0", out_srcid, 0);
      cyc(); chk("bp_src1", out_srcid, 1);
      out_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         cyc();
         chk($sformatf("bp_ready%0d", k), rdy_seen, 0);
         chk($sformatf("bp_valid%0d", k), out_valid, 1);
         chk($sformatf("bp_src%0d", k), out_srcid, 1);
         chk($sformatf("bp_pay%0d", k), out_payload, pay(1, 0));
      end
      out_ready = 1'b1;
      cyc();
      chk("bp_rel_ready", rdy_seen, 4'b0001);
      chk("bp_rel_src", out_srcid, 0);
      chk("bp_rel_valid", out_valid, 1);

      // Reset during a three-beat packet drops the lock and the slot.
      setup(0,0,1,0, 0,0,0,0);
      len[2] = 3;
      do_reset();
      cyc(); chk("mr_lock0", lock_active, 1);
      cyc(); chk("mr_pay1", out_payload, pay(2, 1));
      rst = 1'b1;
      #1;
      chk("mr_valid", out_valid, 0);
      chk("mr_lock", lock_active, 0);
      chk("mr_ready", in_ready, 0);
      setup(0,1,1,1, 0,0,0,0);
      beat = '{0, 0, 0, 0};
      drive();
      @(posedge clk); #1;
      rst = 1'b0;
      cyc();
      chk("mr_post_ready", rdy_seen, 4'b0010);
      chk("mr_post_src", out_srcid, 1);

      // Two high-class sources alternate until low-class source 0 is promoted.
      setup(1,0,1,1, 0,0,1,1);
      do_reset();
      for (int k = 0; k < 9; k++) begin
         cyc();
         chk($sformatf("hq_src%0d", k), out_srcid, exp6[k]);
      end

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end
endmodule
